// File: rtl/uart_tx_buf.sv
// Byte FIFO plus pacer feeding uart_tx: bursty input strobes are re-issued at most once per UART frame.
// Optional build macro UART_TX_BUF_DROP_OLDEST_EN: a write into a full FIFO overwrites the oldest byte.
module uart_tx_buf #(
  parameter int ADDR_W     = 8,
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FRAME_BITS = 11
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        pi_data,
  input  logic              pi_flag,
  output logic [7:0]        po_data,
  output logic              po_flag,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   fill_cnt,
  output logic              overflow
);

  localparam int DEPTH       = 2**ADDR_W;
  localparam int BYTE_CYCLES = (CLK_FREQ / UART_BPS) * FRAME_BITS;
  localparam int CNT_W       = $clog2(BYTE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BYTE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [7:0]        pop_byte;
  logic [CNT_W-1:0]  pace_cnt;

  logic              pop;
  logic              wr_en;
  logic              wr_drop;
  logic              rd_adv;
  logic [ADDR_W:0]   fill_nxt;

  always_comb begin
    pop     = (state == IDLE) && !empty;
    wr_drop = pi_flag && full;
`ifdef UART_TX_BUF_DROP_OLDEST_EN
    // Overwriting when full retires the oldest slot; a same-cycle pop already does that.
    wr_en  = pi_flag;
    rd_adv = pop || wr_drop;
`else
    wr_en  = pi_flag && !full;
    rd_adv = pop;
`endif
    fill_nxt = fill_cnt;
    if (wr_en && !rd_adv)
      fill_nxt = fill_cnt + FILL_ONE;
    else if (!wr_en && rd_adv)
      fill_nxt = fill_cnt - FILL_ONE;
  end

  // Storage and pop capture carry no reset; pointer reset makes old contents unreachable.
  always_ff @(posedge sys_clk) begin
    if (wr_en)
      mem[wr_ptr] <= pi_data;
    if (pop)
      pop_byte <= mem[rd_ptr];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_adv)
        rd_ptr <= rd_ptr + PTR_ONE;
      fill_cnt <= fill_nxt;
      full     <= (fill_nxt == FILL_MAX);
      empty    <= (fill_nxt == '0);
      if (wr_drop)
        overflow <= 1'b1;
    end
  end

  // Pacer: IDLE pops, SEND strobes once, WAIT holds off for one full frame.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      po_flag  <= 1'b0;
      po_data  <= '0;
      pace_cnt <= '0;
    end else begin
      po_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty)
            state <= SEND;
        end
        SEND: begin
          po_data  <= pop_byte;
          po_flag  <= 1'b1;
          pace_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          pace_cnt <= pace_cnt + CNT_ONE;
          if (pace_cnt == CNT_LAST)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
